// File: rtl/seq_input_checker.sv
// Player key-entry checker: compares debounced key presses against a latched 5-digit sequence.
// Optional inactivity timeout is compiled in with `define SEQ_CHECK_TIMEOUT_EN.
module seq_input_checker #(
    parameter int DIGITS         = 5,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int CNT_W          = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  curLvl,
    input  logic [19:0] seq,
    input  logic        keyValid,
    input  logic [3:0]  keyVal,
    output logic        busy,
    output logic [2:0]  idx,
    output logic [3:0]  lastKey,
    output logic        pass,
    output logic        fail,
    output logic        timedOut
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PASS    = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [19:0] seq_r, seq_s;
    logic [2:0]  need_r, need_s;
    logic [2:0]  idx_s;
    logic [3:0]  last_s;

`ifdef SEQ_CHECK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             tout_r, tout_s;
`else
    localparam int unused_cfg = CNT_W + TIMEOUT_CYCLES;
`endif

    function automatic logic [2:0] clamp_need(input logic [2:0] lvl);
        logic [2:0] n;
        if (lvl == 3'd0) begin
            n = 3'd1;
        end else if (lvl > 3'(DIGITS)) begin
            n = 3'(DIGITS);
        end else begin
            n = lvl;
        end
        return n;
    endfunction

    // Digit 0 is the most significant nibble.
    function automatic logic [3:0] digit_at(input logic [19:0] s, input logic [2:0] i);
        logic [3:0] d;
        case (i)
            3'd0:    d = s[19:16];
            3'd1:    d = s[15:12];
            3'd2:    d = s[11:8];
            3'd3:    d = s[7:4];
            3'd4:    d = s[3:0];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // Next-state and next-register computation.
    always_comb begin
        state_s = state_r;
        seq_s   = seq_r;
        need_s  = need_r;
        idx_s   = idx;
        last_s  = lastKey;
`ifdef SEQ_CHECK_TIMEOUT_EN
        cnt_s   = cnt_r;
        tout_s  = 1'b0;
`endif
        case (state_r)
            // A verdict state also accepts start so a new round can begin right after it.
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    seq_s   = seq;
                    need_s  = clamp_need(curLvl);
                    idx_s   = 3'd0;
                    state_s = ST_COLLECT;
`ifdef SEQ_CHECK_TIMEOUT_EN
                    cnt_s   = {CNT_W{1'b0}};
`endif
                end else begin
                    idx_s   = 3'd0;
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (keyValid) begin
                    last_s = keyVal;
`ifdef SEQ_CHECK_TIMEOUT_EN
                    cnt_s  = {CNT_W{1'b0}};
`endif
                    if (keyVal != digit_at(seq_r, idx)) begin
                        state_s = ST_FAIL;
                    end else if (idx == need_r - 3'd1) begin
                        state_s = ST_PASS;
                    end else begin
                        idx_s = idx + 3'd1;
                    end
                end
`ifdef SEQ_CHECK_TIMEOUT_EN
                else if (cnt_r == CNT_LAST) begin
                    state_s = ST_FAIL;
                    tout_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                else begin
                    state_s = ST_COLLECT;
                end
`endif
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 3'd0;
            end
        endcase
    end

    // State and registered Moore outputs; rst is synchronous active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            seq_r   <= 20'd0;
            need_r  <= 3'd1;
            busy    <= 1'b0;
            idx     <= 3'd0;
            lastKey <= 4'd0;
            pass    <= 1'b0;
            fail    <= 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
            cnt_r   <= {CNT_W{1'b0}};
            tout_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            seq_r   <= seq_s;
            need_r  <= need_s;
            busy    <= (state_s == ST_COLLECT);
            idx     <= idx_s;
            lastKey <= last_s;
            pass    <= (state_s == ST_PASS);
            fail    <= (state_s == ST_FAIL);
`ifdef SEQ_CHECK_TIMEOUT_EN
            cnt_r   <= cnt_s;
            tout_r  <= tout_s;
`endif
        end
    end

`ifdef SEQ_CHECK_TIMEOUT_EN
    assign timedOut = tout_r;
`else
    assign timedOut = 1'b0;
`endif

endmodule

// File: tb/tb_seq_input_checker.sv
// Self-checking bench for seq_input_checker with a round-level reference model.
module tb_seq_input_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  curLvl;
    logic [19:0] seq;
    logic        keyValid;
    logic [3:0]  keyVal;
    logic        busy;
    logic [2:0]  idx;
    logic [3:0]  lastKey;
    logic        pass;
    logic        fail;
    logic        timedOut;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_last = 4'd0;

    typedef logic [3:0] keys_t [5];

    seq_input_checker #(
        .DIGITS(5),
        .TIMEOUT_CYCLES(20),
        .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .curLvl(curLvl), .seq(seq),
        .keyValid(keyValid), .keyVal(keyVal), .busy(busy), .idx(idx),
        .lastKey(lastKey), .pass(pass), .fail(fail), .timedOut(timedOut)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {busy, idx, lastKey, pass, fail, timedOut}
    function automatic logic [11:0] obs();
        return {busy, idx, lastKey, pass, fail, timedOut};
    endfunction

    function automatic logic [11:0] mk(input logic b, input logic [2:0] i, input logic [3:0] l,
                                       input logic p, input logic f, input logic t);
        return {b, i, l, p, f, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; keyValid = 1'b0; keyVal = 4'd0; curLvl = 3'd0; seq = 20'd0;
        tick(); tick();
        total++;
        if (obs() !== mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset: got %h want %h", obs(), mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b1;
        tick();
        exp_last = 4'd0;
    endtask

    // Runs one round; the model derives each expected digit directly from the sequence value.
    task automatic run_round(input string name, input logic [19:0] s, input logic [2:0] lvl,
                             input keys_t keys, input int gap_max, input bit early_start,
                             input bit zero_after);
        int need;
        int gap;
        bit done;
        logic [3:0] want;
        logic [11:0] e;
        need = (lvl == 3'd0) ? 1 : ((lvl > 3'd5) ? 5 : int'(lvl));
        seq = s; curLvl = lvl; start = 1'b1;
        tick();
        start = 1'b0;
        seq = zero_after ? 20'h00000 : 20'($urandom);
        curLvl = 3'($urandom);
        e = mk(1'b1, 3'd0, exp_last, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL %s_start: got %h want %h", name, obs(), e); end
        done = 1'b0;
        for (int i = 0; i < need && !done; i++) begin
            gap = $urandom_range(gap_max, 0);
            for (int g = 0; g < gap; g++) begin
                start = 1'($urandom);
                tick();
                start = 1'b0;
                e = mk(1'b1, 3'(i), exp_last, 1'b0, 1'b0, 1'b0);
                total++;
                if (obs() !== e) begin bad++; $display("FAIL %s_gap: got %h want %h", name, obs(), e); end
            end
            keyValid = 1'b1; keyVal = keys[i];
            tick();
            keyValid = 1'b0;
            exp_last = keys[i];
            want = s[4*(4-i) +: 4];
            if (keys[i] != want) begin
                e = mk(1'b0, 3'(i), exp_last, 1'b0, 1'b1, 1'b0);
                done = 1'b1;
            end else if (i == need - 1) begin
                e = mk(1'b0, 3'(i), exp_last, 1'b1, 1'b0, 1'b0);
                done = 1'b1;
            end else begin
                e = mk(1'b1, 3'(i + 1), exp_last, 1'b0, 1'b0, 1'b0);
            end
            total++;
            if (obs() !== e) begin bad++; $display("FAIL %s_key%0d: got %h want %h", name, i, obs(), e); end
        end
        if (!early_start) begin
            tick();
            e = mk(1'b0, 3'd0, exp_last, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL %s_after: got %h want %h", name, obs(), e); end
        end
    endtask

    task automatic test_plan();
        keys_t k;
        k = '{4'h7, 4'h9, 4'hB, 4'hC, 4'hC};
        run_round("pass5", 20'h79BCC, 3'd5, k, 0, 1'b0, 1'b0);
        k = '{4'h7, 4'h9, 4'hA, 4'h0, 4'h0};
        run_round("fail3", 20'h79BCC, 3'd3, k, 0, 1'b0, 1'b0);
        k = '{4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        run_round("lvl0", 20'h79BCC, 3'd0, k, 0, 1'b0, 1'b0);
        k = '{4'h7, 4'h9, 4'hB, 4'hC, 4'hC};
        run_round("lvl7", 20'h79BCC, 3'd7, k, 1, 1'b0, 1'b0);
        run_round("seqchg", 20'h79BCC, 3'd5, k, 1, 1'b0, 1'b1);
        k = '{4'h7, 4'h9, 4'hB, 4'hC, 4'hD};
        run_round("lastbad", 20'h79BCC, 3'd6, k, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_with_key();
        logic [11:0] e;
        seq = 20'h79BCC; curLvl = 3'd1; start = 1'b1; keyValid = 1'b1; keyVal = 4'h3;
        tick();
        start = 1'b0; keyValid = 1'b0;
        e = mk(1'b1, 3'd0, exp_last, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL start_key_drop: got %h want %h", obs(), e); end
        keyValid = 1'b1; keyVal = 4'h7;
        tick();
        keyValid = 1'b0;
        exp_last = 4'h7;
        e = mk(1'b0, 3'd0, 4'h7, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL start_key_pass: got %h want %h", obs(), e); end
        tick();
    endtask

    task automatic test_back_to_back();
        keys_t k;
        k = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        run_round("b2b_a", 20'h12345, 3'd2, k, 0, 1'b1, 1'b0);
        run_round("b2b_b", 20'h12345, 3'd4, k, 0, 1'b1, 1'b0);
        k = '{4'h1, 4'h9, 4'h3, 4'h4, 4'h5};
        run_round("b2b_c", 20'h12345, 3'd4, k, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        keys_t k;
        logic [19:0] s;
        for (int r = 0; r < 40; r++) begin
            s = 20'($urandom);
            for (int i = 0; i < 5; i++) begin
                k[i] = ($urandom_range(7, 0) == 0) ? 4'($urandom) : s[4*(4-i) +: 4];
            end
            run_round("rand", s, 3'($urandom), k, 3, 1'($urandom), 1'b0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        keys_t k;
        seq = 20'h79BCC; curLvl = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        keyValid = 1'b1; keyVal = 4'h7; tick();
        keyVal = 4'h9; tick();
        keyValid = 1'b0;
        e = mk(1'b1, 3'd2, 4'h9, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL rstmid_pre: got %h want %h", obs(), e); end
        rst = 1'b0;
        keyValid = 1'b1; keyVal = 4'hB;
        tick();
        rst = 1'b1; keyValid = 1'b0;
        exp_last = 4'd0;
        e = mk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL rstmid_edge: got %h want %h", obs(), e); end
        tick();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL rstmid_after: got %h want %h", obs(), e); end
        k = '{4'h7, 4'h9, 4'hB, 4'hC, 4'hC};
        run_round("rstmid_fresh", 20'h79BCC, 3'd5, k, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        logic [11:0] e;
        seq = 20'h79BCC; curLvl = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
        for (int c = 1; c < 20; c++) begin
            tick();
            e = mk(1'b1, 3'd0, exp_last, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL to_wait%0d: got %h want %h", c, obs(), e); end
        end
        tick();
        e = mk(1'b0, 3'd0, exp_last, 1'b0, 1'b1, 1'b1);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_fire: got %h want %h", obs(), e); end
        tick();
        e = mk(1'b0, 3'd0, exp_last, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_after: got %h want %h", obs(), e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        keyValid = 1'b1; keyVal = 4'h7;
        tick();
        keyValid = 1'b0;
        exp_last = 4'h7;
        e = mk(1'b1, 3'd1, 4'h7, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_keywins: got %h want %h", obs(), e); end
        for (int c = 1; c < 20; c++) begin
            tick();
            e = mk(1'b1, 3'd1, 4'h7, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL to_rewait%0d: got %h want %h", c, obs(), e); end
        end
        tick();
        e = mk(1'b0, 3'd1, 4'h7, 1'b0, 1'b1, 1'b1);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL to_refire: got %h want %h", obs(), e); end
        tick();
`else
        for (int c = 1; c < 40; c++) begin
            tick();
            e = mk(1'b1, 3'd0, exp_last, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL noto_wait%0d: got %h want %h", c, obs(), e); end
        end
        keyValid = 1'b1; keyVal = 4'h0;
        tick();
        keyValid = 1'b0;
        exp_last = 4'h0;
        e = mk(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL noto_key: got %h want %h", obs(), e); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_plan();
        test_start_with_key();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
